// File: rtl/key_hash_pkg.sv
// Shared types and helpers for the multi-width key hasher: FSM encoding,
// beat counting and last-beat byte masking.
package key_hash_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_FOLD = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   // Upper bound on bytes per beat; masks are built this wide and cast down.
   localparam int unsigned MAX_BYTES = 128;

   function automatic int unsigned ceil_beats(input int unsigned len,
                                              input int unsigned bytes);
      return (len + bytes - 1) / bytes;
   endfunction

   // rem == 0 means the last beat is full, so every byte is kept.
   function automatic logic [MAX_BYTES-1:0] tail_mask(input int unsigned rem);
      logic [MAX_BYTES-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
         m[i] = (rem == 0) || (i < rem);
      end
      return m;
   endfunction

endpackage

// File: rtl/key_hash_multi_if.sv
// FIFO-side bundle of the key hasher: length FIFO and key FIFO reads, hash FIFO write.
// Handshake: a pop/write happens in exactly the cycle its *_en is high; *_en never
// rises while the matching FIFO reports empty/full, and FWFT data is valid while !empty.
interface key_hash_multi_if #(
   parameter int DATA_W = 128,
   parameter int LEN_W  = 8,
   parameter int H1_W   = 28,
   parameter int H2_W   = 24,
   parameter int H3_W   = 5,
   parameter int CNT_W  = 16
);
   logic              iRdKeyLenEmpty;
   logic [LEN_W-1:0]  iKeyLen;
   logic              iMode;
   logic              oRdKeyLenFifo_en;
   logic              iRdKeyEmpty;
   logic [DATA_W-1:0] iKey;
   logic              oRdKeyFifo_en;
   logic              iWrHashFull;
   logic              oWrHashFifo_en;
   logic [H1_W-1:0]   oKeyHash_1;
   logic [H2_W-1:0]   oKeyHash_2;
   logic [H3_W-1:0]   oKeyHash_3;
   logic [LEN_W-1:0]  oKeyLen;
   logic [CNT_W-1:0]  oKeyCount;

   modport slave (
      input  iRdKeyLenEmpty, iKeyLen, iMode, iRdKeyEmpty, iKey, iWrHashFull,
      output oRdKeyLenFifo_en, oRdKeyFifo_en, oWrHashFifo_en,
             oKeyHash_1, oKeyHash_2, oKeyHash_3, oKeyLen, oKeyCount
   );

   modport master (
      output iRdKeyLenEmpty, iKeyLen, iMode, iRdKeyEmpty, iKey, iWrHashFull,
      input  oRdKeyLenFifo_en, oRdKeyFifo_en, oWrHashFifo_en,
             oKeyHash_1, oKeyHash_2, oKeyHash_3, oKeyLen, oKeyCount
   );
endinterface

// File: rtl/hash_fold.sv
// Combinational reducer: XOR of consecutive OUT_W-bit slices of the input,
// starting at bit 0, with the top partial slice zero-extended.
module hash_fold #(
   parameter int IN_W  = 128,
   parameter int OUT_W = 28
) (
   input  logic [IN_W-1:0]  i_data,
   output logic [OUT_W-1:0] o_hash
);
   localparam int NSL   = (IN_W + OUT_W - 1) / OUT_W;
   localparam int PAD_W = NSL * OUT_W;

   logic [PAD_W-1:0] w_pad;

   assign w_pad = PAD_W'(i_data);

   always_comb begin
      o_hash = '0;
      for (int i = 0; i < NSL; i++) begin
         o_hash = o_hash ^ w_pad[i*OUT_W +: OUT_W];
      end
   end
endmodule

// File: rtl/key_hash_multi.sv
// Streams one variable-length key per transaction into a DATA_W accumulator
// (XOR or rotate-XOR mix) and folds it into three hash widths for the hash FIFO.
module key_hash_multi
   import key_hash_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int LEN_W  = 8,
   parameter int H1_W   = 28,
   parameter int H2_W   = 24,
   parameter int H3_W   = 5,
   parameter int ROT    = 13,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   key_hash_multi_if.slave   bus,
   output state_t            o_dbg_state
);
   localparam int unsigned BYTES = DATA_W / 8;

   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_acc, w_beat, w_mix;
   logic [LEN_W-1:0]  r_len, r_beats, r_out_len;
   logic              r_mode;
   logic [H1_W-1:0]   r_h1, w_h1;
   logic [H2_W-1:0]   r_h2, w_h2;
   logic [H3_W-1:0]   r_h3, w_h3;
   logic [CNT_W-1:0]  r_count;
   logic [BYTES-1:0]  w_keep;
   logic              w_len_pop, w_key_pop, w_write, w_last;

   assign w_len_pop = (r_state == S_IDLE) && !bus.iRdKeyLenEmpty;
   assign w_key_pop = (r_state == S_DATA) && !bus.iRdKeyEmpty;
   assign w_write   = (r_state == S_OUT)  && !bus.iWrHashFull;
   assign w_last    = (r_beats == LEN_W'(1));
   assign w_keep    = BYTES'(tail_mask(32'(r_len) % BYTES));

   // Only the final beat of a key can carry bytes past the key length.
   always_comb begin
      w_beat = bus.iKey;
      for (int i = 0; i < int'(BYTES); i++) begin
         if (w_last && !w_keep[i]) w_beat[8*i +: 8] = 8'h00;
      end
   end

   assign w_mix = r_mode ? (((r_acc << ROT) | (r_acc >> (DATA_W - ROT))) ^ w_beat)
                         : (r_acc ^ w_beat);

   hash_fold #(.IN_W(DATA_W), .OUT_W(H1_W)) u_fold1 (.i_data(r_acc), .o_hash(w_h1));
   hash_fold #(.IN_W(DATA_W), .OUT_W(H2_W)) u_fold2 (.i_data(r_acc), .o_hash(w_h2));
   hash_fold #(.IN_W(DATA_W), .OUT_W(H3_W)) u_fold3 (.i_data(r_acc), .o_hash(w_h3));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_len_pop) w_next = (bus.iKeyLen == '0) ? S_FOLD : S_DATA;
         S_DATA:  if (w_key_pop && w_last) w_next = S_FOLD;
         S_FOLD:  w_next = S_OUT;
         S_OUT:   if (w_write) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_len     <= '0;
         r_beats   <= '0;
         r_mode    <= 1'b0;
         r_out_len <= '0;
         r_h1      <= '0;
         r_h2      <= '0;
         r_h3      <= '0;
         r_count   <= '0;
      end else begin
         if (w_len_pop) begin
            r_len   <= bus.iKeyLen;
            r_mode  <= bus.iMode;
            r_acc   <= '0;
            r_beats <= LEN_W'(ceil_beats(32'(bus.iKeyLen), BYTES));
         end
         if (w_key_pop) begin
            r_acc   <= w_mix;
            r_beats <= r_beats - LEN_W'(1);
         end
         if (r_state == S_FOLD) begin
            r_h1      <= w_h1;
            r_h2      <= w_h2;
            r_h3      <= w_h3;
            r_out_len <= r_len;
         end
         if (w_write) r_count <= r_count + CNT_W'(1);
      end
   end

   assign bus.oRdKeyLenFifo_en = w_len_pop;
   assign bus.oRdKeyFifo_en    = w_key_pop;
   assign bus.oWrHashFifo_en   = w_write;
   assign bus.oKeyHash_1       = r_h1;
   assign bus.oKeyHash_2       = r_h2;
   assign bus.oKeyHash_3       = r_h3;
   assign bus.oKeyLen          = r_out_len;
   assign bus.oKeyCount        = r_count;
   assign o_dbg_state          = r_state;
endmodule
